// File: rtl/div_multi_cycle.sv
// Iterative radix-2 restoring unsigned divider with valid/ready handshakes on both sides.
// One quotient bit is produced per clock; the dividend shift register doubles as the quotient register.
module div_multi_cycle #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  divZero_q, divZero_d;

  logic [DIVISOR_W:0]    remShift;
  logic                  qBit;
  logic [DIVISOR_W-1:0]  remNext;
  logic [DIVIDEND_W-1:0] quotShift;
  logic                  lastStep;
  logic                  dvsIsZero;

  // The stored remainder is always below the divisor, so after the shift it fits in DIVISOR_W+1 bits.
  always_comb begin
    remShift  = {rem_q, dvd_q[DIVIDEND_W-1]};
    qBit      = (remShift >= {1'b0, dvs_q});
    remNext   = qBit ? DIVISOR_W'(remShift - {1'b0, dvs_q}) : remShift[DIVISOR_W-1:0];
    quotShift = {dvd_q[DIVIDEND_W-2:0], qBit};
    lastStep  = (count_q == CNT_W'(1));
    dvsIsZero = (dvs_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (lastStep)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Result registers are written only on the step that enters DONE, so they hold through the drain.
  always_comb begin
    count_d     = count_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divZero_d   = divZero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          count_d = CNT_LOAD;
        end
      end
      BUSY: begin
        dvd_d   = quotShift;
        rem_d   = remNext;
        count_d = count_q - CNT_W'(1);
        if (lastStep) begin
          quotient_d  = dvsIsZero ? '1 : quotShift;
          remainder_d = dvsIsZero ? '0 : remNext;
          divZero_d   = dvsIsZero;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divZero_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divZero_q   <= divZero_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = divZero_q;

endmodule
